// File: rtl/rf_read_port_pkg.sv
// Shared definitions for the register-file read side: data/address widths,
// the hard-wired zero register and the writeback data-select encodings.
package rf_read_port_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    RF_WD_ALU = 2'd0,
    RF_WD_MEM = 2'd1,
    RF_WD_PC4 = 2'd2,
    RF_WD_IMM = 2'd3
  } rf_wd_sel_e;

endpackage

// File: rtl/rf_src_resolve.sv
// Resolves one source operand: x0 reads zero, a same-cycle writeback is
// forwarded, otherwise the stored value is used and a pending load blocks it.
module rf_src_resolve
  import rf_read_port_pkg::*;
(
  input  logic [AW-1:0]   rr_i,
  input  logic            we_i,
  input  logic [AW-1:0]   wr_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [XLEN-1:0] reg_val_i,
  input  logic            pend_i,
  output logic [XLEN-1:0] val_o,
  output logic            blocked_o
);

  // Forwarding beats the scoreboard: the writeback is the result being waited on.
  always_comb begin
    val_o     = '0;
    blocked_o = 1'b0;
    if (rr_i == ZERO_REG) begin
      val_o     = '0;
      blocked_o = 1'b0;
    end else if (we_i && (wr_i == rr_i)) begin
      val_o     = wd_i;
      blocked_o = 1'b0;
    end else begin
      val_o     = reg_val_i;
      blocked_o = pend_i;
    end
  end

endmodule

// File: rtl/rf_read_port.sv
// Register file storage with one write port, a pending-load scoreboard and a
// dual-source read port with bypass and a one-cycle registered response.
module rf_read_port
  import rf_read_port_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            WE,
  input  logic [AW-1:0]   wR,
  input  logic [XLEN-1:0] WD,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_rd,
  input  logic            rd_req,
  input  logic [AW-1:0]   rR1,
  input  logic [AW-1:0]   rR2,
  output logic            rd_ready,
  output logic            rd_valid,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            flush
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic            rd_valid_q, rd_valid_d;
  logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d;

  logic [XLEN-1:0] src1_val, src2_val;
  logic            src1_blk, src2_blk;
  logic            accept;

  rf_src_resolve u_src1 (
    .rr_i      (rR1),
    .we_i      (WE),
    .wr_i      (wR),
    .wd_i      (WD),
    .reg_val_i (regs_q[rR1]),
    .pend_i    (pend_q[rR1]),
    .val_o     (src1_val),
    .blocked_o (src1_blk)
  );

  rf_src_resolve u_src2 (
    .rr_i      (rR2),
    .we_i      (WE),
    .wr_i      (wR),
    .wd_i      (WD),
    .reg_val_i (regs_q[rR2]),
    .pend_i    (pend_q[rR2]),
    .val_o     (src2_val),
    .blocked_o (src2_blk)
  );

  assign rd_ready = rd_req && !src1_blk && !src2_blk;
  assign accept   = rd_ready && !flush;

  // Register storage; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (WE && (wR != ZERO_REG)) begin
      regs_q[wR] <= WD;
    end
  end

  // A new load issue outranks a same-cycle writeback to the same register.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREG; i++) begin
      if (i == 0) begin
        pend_d[i] = 1'b0;
      end else if (sb_set && (sb_rd == AW'(i))) begin
        pend_d[i] = 1'b1;
      end else if (WE && (wR == AW'(i))) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // Response capture: data only moves on an accepted, unflushed request.
  always_comb begin
    rd_valid_d = 1'b0;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    if (accept) begin
      rd_valid_d = 1'b1;
      rd1_d      = src1_val;
      rd2_d      = src2_val;
    end else begin
      rd_valid_d = 1'b0;
      rd1_d      = rd1_q;
      rd2_d      = rd2_q;
    end
  end

  // Scoreboard and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      rd_valid_q <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
    end else begin
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign RD1      = rd1_q;
  assign RD2      = rd2_q;

endmodule

// File: tb/tb_rf_read_port.sv
// Scoreboard bench for rf_read_port: directed scenarios followed by random
// traffic, checked against an array-based model of the register file.
module tb_rf_read_port;

  logic        clk;
  logic        rst;
  logic        WE;
  logic [4:0]  wR;
  logic [31:0] WD;
  logic        sb_set;
  logic [4:0]  sb_rd;
  logic        rd_req;
  logic [4:0]  rR1;
  logic [4:0]  rR2;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        flush;

  rf_read_port dut (
    .clk      (clk),
    .rst      (rst),
    .WE       (WE),
    .wR       (wR),
    .WD       (WD),
    .sb_set   (sb_set),
    .sb_rd    (sb_rd),
    .rd_req   (rd_req),
    .rR1      (rR1),
    .rR2      (rR2),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .RD1      (RD1),
    .RD2      (RD2),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] m_regs [32];
  logic        m_pend [32];
  logic [31:0] m_last1 = 32'd0;
  logic [31:0] m_last2 = 32'd0;
  logic        m_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand value the architecture would deliver, and whether it must wait.
  function automatic logic [31:0] m_val(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (WE && wR == r) return WD;
    return m_regs[r];
  endfunction

  function automatic logic m_blk(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (WE && wR == r) return 1'b0;
    return m_pend[r];
  endfunction

  task automatic step(input logic r, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic sbs, input logic [4:0] sbr, input logic req,
                      input logic [4:0] r1, input logic [4:0] r2, input logic fl);
    exp_t        e;
    logic [31:0] v1, v2;
    @(negedge clk);
    rst = r; WE = we; wR = wr; WD = wd; sb_set = sbs; sb_rd = sbr;
    rd_req = req; rR1 = r1; rR2 = r2; flush = fl;
    #1;
    m_ready = req && !m_blk(r1) && !m_blk(r2);
    v1 = m_val(r1);
    v2 = m_val(r2);
    chk("rd_ready", {31'd0, rd_ready}, {31'd0, m_ready});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_pend[i] = 1'b0;
      end
      m_last1 = 32'd0;
      m_last2 = 32'd0;
      e.v = 1'b0;
    end else begin
      if (m_ready && !fl) begin
        m_last1 = v1;
        m_last2 = v2;
        e.v = 1'b1;
      end else begin
        e.v = 1'b0;
      end
      if (we && wr != 5'd0) begin
        m_regs[wr] = wd;
        m_pend[wr] = 1'b0;
      end
      if (sbs && sbr != 5'd0) m_pend[sbr] = 1'b1;
    end
    e.d1 = m_last1;
    e.d2 = m_last2;
    sbq.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, r1, r2, 1'b0);
  endtask

  // Monitor: compare each registered response against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, e.v});
        chk("RD1", RD1, e.d1);
        chk("RD2", RD2, e.d2);
      end
    end
  end

  initial begin
    logic       hold;
    logic [4:0] h1, h2;
    logic       r, we, sbs, req, fl;
    logic [4:0] wr, sbr, r1, r2;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
    rst = 1'b1; WE = 1'b0; wR = 5'd0; WD = 32'd0; sb_set = 1'b0; sb_rd = 5'd0;
    rd_req = 1'b0; rR1 = 5'd0; rR2 = 5'd0; flush = 1'b0;

    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd4, 5'd4, 1'b0);
    rd(5'd5, 5'd0);
    step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b1, 5'd3, 5'd0, 1'b0);
    rd(5'd0, 5'd3);
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    rd(5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) rd(5'd3, 5'd7);
    step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b1, 5'd3, 5'd7, 1'b0);
    rd(5'd7, 5'd7);
    step(1'b0, 1'b1, 5'd9, 32'h00000011, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 1'b0);
    rd(5'd9, 5'd0);
    step(1'b0, 1'b1, 5'd9, 32'h00000022, 1'b0, 5'd0, 1'b1, 5'd9, 5'd0, 1'b0);
    rd(5'd9, 5'd9);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd9, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 1'b0);
    rd(5'd7, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 1'b0);
    rd(5'd7, 5'd3);
    idle();

    hold = 1'b0; h1 = 5'd0; h2 = 5'd0;
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      we  = ($urandom_range(0, 1) == 1);
      wr  = 5'($urandom_range(0, 7));
      sbs = ($urandom_range(0, 3) == 0);
      sbr = 5'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 9) == 0);
      if (hold) begin
        req = 1'b1; r1 = h1; r2 = h2;
      end else begin
        req = ($urandom_range(0, 3) != 0);
        r1  = 5'($urandom_range(0, 9));
        r2  = 5'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) r1 = 5'($urandom_range(0, 31));
      end
      step(r, we, wr, $urandom, sbs, sbr, req, r1, r2, fl);
      hold = req && !m_ready && !r;
      h1 = r1;
      h2 = r2;
    end

    idle();
    idle();
    #2;
    chk("sbq_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
